sysid_regs: RTL
===============

Name: sysid_regs

Overview:
- Parametrised successor to the fixed two-word system ID slave.
- Memory-mapped, read-mostly Avalon-MM slave. It returns system ID, build timestamp, a 64-bit uptime counter with atomic readout, a scratch register, and a capability word.
- Read data is registered with a configurable latency and a readdatavalid strobe.
- Sits on the CPU data master's interconnect and is used by boot software to identify the hardware build.

Parameters:
- ID_VALUE, 32'h0000_0000, value returned at word 0.
- TIMESTAMP_VALUE, 32'h56E1_0AAA, build timestamp returned at word 1.
- ADDR_WIDTH, 3, word address width; must be at least 3.
- READ_LATENCY, 1, cycles from read to readdatavalid; legal values 1 or 2.
- PRESCALE, 1, clocks per uptime increment; must be at least 1.
- SCRATCH_RESET, 32'h0000_0000, reset value of the scratch register.
- BLOCK_VERSION, 16'h0002, reported in the capability word.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read request, single-cycle.
- write  in  1  write request, single-cycle.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  one-cycle strobe qualifying readdata.

Behaviour:
- Reset (async assert, sync release): readdata=0, readdatavalid=0, pipeline empty, uptime=0, prescaler=0, hi_shadow=0, scratch=SCRATCH_RESET.
- No waitrequest. A read is accepted every cycle it is asserted; back-to-back reads are legal and pipelined.
- Register map (word addresses):
  - 0: ID_VALUE, read-only.
  - 1: TIMESTAMP_VALUE, read-only.
  - 2: UPTIME_LO = uptime[31:0]. Reading it latches uptime[63:32] into hi_shadow in the same cycle.
  - 3: hi_shadow, read-only.
  - 4: SCRATCH, read/write.
  - 5: CAP. Reads {BLOCK_VERSION[15:0], 6'd0, READ_LATENCY[1:0], 7'd0, UPTIME_PRESENT}. Writing bit0=1 clears uptime and prescaler; other bits are ignored.
  - 6 and above: read 0, writes ignored.
- Read data is sampled from register state at the cycle read is asserted.
  - READ_LATENCY=1: readdata and readdatavalid are updated on the next edge.
  - READ_LATENCY=2: one extra register stage is added.
- readdatavalid is high for exactly one cycle per read.
- readdata holds its last value between reads.
- read and write in the same cycle, same address: the write takes effect, and the read returns the pre-write value.
- Writes to read-only words have no side effect.
- Prescaler counts 0..PRESCALE-1. On the cycle it wraps, uptime increments by 1. With PRESCALE=1, uptime increments every clock.
- Uptime wraps 2^64-1 -> 0 with no flag.
- A CAP clear in the same cycle as an increment takes priority: uptime=0 and prescaler=0 on the next edge.
- A read of word 2 in the same cycle as a clear returns the pre-clear low word and latches the pre-clear high word.
- Reset mid-read: the pending readdatavalid is dropped and not emitted after release.

Optional Feature:
- Macro: SYSID_UPTIME_EN.
- Defined: uptime counter, prescaler and hi_shadow are present. CAP bit0 reads 1 (UPTIME_PRESENT=1).
- Undefined: no counter logic is generated. Words 2 and 3 read 0, CAP bit0 reads 0, and CAP clear writes are ignored.
- Read timing is identical in both builds.

Test Plan:
- Reset, then read words 0, 1, 5 with defaults (macro defined) -> readdata 0, 32'h56E1_0AAA, 32'h0002_0101. readdatavalid appears 1 cycle after each read; back-to-back reads give 3 consecutive valid strobes.
- Write 32'hDEAD_BEEF to word 4, then read word 4 -> 32'hDEAD_BEEF. Simultaneous read+write of 32'h1234_5678 -> read returns 32'hDEAD_BEEF; a subsequent read returns 32'h1234_5678.
- Force uptime to 64'h0000_0001_FFFF_FFFF via a bench hook with PRESCALE=1. Read word 2, then word 3 -> low FFFF_FFFF, high 1. The high word must not read 2 even though uptime crossed the 32-bit boundary.
- PRESCALE=4: clear via CAP, wait 40 clocks, read word 2 -> 10 ±1. Clear coincident with an increment -> next read of word 2 returns 0 or 1, never the pre-clear value+1.
- READ_LATENCY=2: read at cycle N -> readdatavalid at N+2 only. Assert reset_n low at N+1 -> no strobe is emitted, readdata=0.
- Build without SYSID_UPTIME_EN -> words 2 and 3 read 0, CAP reads 32'h0002_0100, and the read-only words still read correctly.

Source files
------------

// File: rtl/sysid_regs.sv
// sysid_regs: read-mostly Avalon-MM system identification slave.
//
// Registered read data with READ_LATENCY of 1 or 2 cycles, qualified by a
// single-cycle readdatavalid strobe. No waitrequest, so reads may issue every
// cycle and are pipelined.
//
// Word map:
//   0 ID_VALUE
//   1 TIMESTAMP_VALUE
//   2 uptime[31:0]
//   3 hi_shadow
//   4 scratch
//   5 capability word
//   6+ reserved, read as zero
//
// Reading word 2 also captures uptime[63:32] into hi_shadow, so software
// reads word 2 and then word 3 to obtain a coherent 64-bit uptime value.
//
// Optional feature macro: SYSID_UPTIME_EN. When it is defined, the uptime
// counter, prescaler and hi_shadow are built. When it is undefined, words 2
// and 3 read zero, CAP bit0 reads zero, and CAP clear writes are ignored.
module sysid_regs #(
  parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h56E1_0AAA,
  parameter int          ADDR_WIDTH      = 3,
  parameter int          READ_LATENCY    = 1,
  parameter int          PRESCALE        = 1,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000,
  parameter logic [15:0] BLOCK_VERSION   = 16'h0002
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  // Reject parameter values the map and the pipeline cannot support.
  if (ADDR_WIDTH < 3 || (READ_LATENCY != 1 && READ_LATENCY != 2) || PRESCALE < 1) begin : g_bad_params
    $error("sysid_regs: illegal parameter value");
  end

  localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_TS      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CAP     = ADDR_WIDTH'(5);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAP_WORD = {BLOCK_VERSION, 6'd0, 2'(READ_LATENCY), 7'd0, UPTIME_PRESENT};

  logic [31:0] scratch;
  logic [31:0] rd_mux;
  logic        out_load;
  logic [31:0] out_data;

  // Scratch register: the only general-purpose writable word.
  // NOTE: sequential state is always assigned with <=, so a read and a write
  // in the same cycle see the pre-write value without any special casing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_RESET;
    end else if (write && address == A_SCRATCH) begin
      scratch <= writedata;
    end
  end

`ifdef SYSID_UPTIME_EN
  localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0]  A_UNUSED  = 2'b00;
  localparam logic [ADDR_WIDTH-1:0] A_UP_LO = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_UP_HI = ADDR_WIDTH'(3);

  logic [63:0]   uptime;
  logic [PW-1:0] prescaler;
  logic [31:0]   hi_shadow;
  logic          cap_clear;
  logic          presc_wrap;

  assign cap_clear  = write && (address == A_CAP) && writedata[0];
  assign presc_wrap = (prescaler == PW'(PRESCALE - 1));

  // Free-running uptime counter; a CAP clear beats a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime    <= '0;
      prescaler <= '0;
    end else if (cap_clear) begin
      uptime    <= '0;
      prescaler <= '0;
    end else if (presc_wrap) begin
      uptime    <= uptime + 64'd1;
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Capture the high word whenever the low word is read, for atomic readout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_shadow <= '0;
    end else if (read && address == A_UP_LO) begin
      hi_shadow <= uptime[63:32];
    end
  end
`endif

  // Read data selection from current register state.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_ID:      rd_mux = ID_VALUE;
      A_TS:      rd_mux = TIMESTAMP_VALUE;
`ifdef SYSID_UPTIME_EN
      A_UP_LO:   rd_mux = uptime[31:0];
      A_UP_HI:   rd_mux = hi_shadow;
`endif
      A_SCRATCH: rd_mux = scratch;
      A_CAP:     rd_mux = CAP_WORD;
      default:   rd_mux = '0;
    endcase
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic        pipe_valid;
    logic [31:0] pipe_data;

    // Extra register stage between the read mux and the output register.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pipe_valid <= 1'b0;
        pipe_data  <= '0;
      end else begin
        pipe_valid <= read;
        if (read) begin
          pipe_data <= rd_mux;
        end
      end
    end

    assign out_load = pipe_valid;
    assign out_data = pipe_data;
  end else begin : g_lat1
    assign out_load = read;
    assign out_data = rd_mux;
  end

  // Output register: readdata holds between reads, and valid pulses once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= out_load;
      if (out_load) begin
        readdata <= out_data;
      end
    end
  end

endmodule
